// File: rtl/aud_recorder.sv
// Codec ADC receiver: deserialises left-channel samples (MSB first while lrck is low)
// into parallel words with a sequential write address and start/pause/stop control.
module aud_recorder #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 20,
  parameter logic [ADDR_W-1:0] ADDR_LAST = 20'hFFFFF
) (
  input  logic              i_bclk,
  input  logic              i_rst_n,
  input  logic              i_adclrck,
  input  logic              i_adcdat,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_address,
  output logic              o_busy,
  output logic              o_done
);

  localparam int               CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_WAITL,
    S_RECV,
    S_WAITH,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic [DATA_W-2:0] shift_reg;
  logic [DATA_W-1:0] shift_next;
  logic              pause_req_reg;
  logic              last_strobe;
  logic              pause_armable;
  logic              start_fresh;

  function automatic logic is_busy(input state_t s);
    return (s == S_SYNC) || (s == S_WAITL) || (s == S_RECV) || (s == S_WAITH);
  endfunction

  // Word being assembled: bits received so far with the current serial bit appended.
  genvar gi;
  generate
    assign shift_next[0] = i_adcdat;
    for (gi = 1; gi < DATA_W; gi++) begin : g_shift
      assign shift_next[gi] = shift_reg[gi-1];
    end
  endgenerate

  assign last_strobe   = o_valid && (o_address == ADDR_LAST);
  assign pause_armable = (state_reg == S_WAITL) || (state_reg == S_WAITH) ||
                         (state_reg == S_RECV);
  assign start_fresh   = (state_next == S_SYNC) &&
                         ((state_reg == S_IDLE) || (state_reg == S_DONE));

  always_comb begin
    state_next = state_reg;
    if (i_stop) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE, S_PAUSE, S_DONE: begin
          if (i_start && !i_pause) state_next = S_SYNC;
        end
        S_SYNC: begin
          if (i_adclrck) state_next = S_WAITH;
        end
        S_WAITH: begin
          // The strobe of the last writable address ends recording before any resync.
          if (last_strobe) begin
            state_next = S_DONE;
          end else if (i_adclrck) begin
            state_next = (pause_req_reg || i_pause) ? S_PAUSE : S_WAITL;
          end
        end
        S_WAITL: begin
          if (i_pause) begin
            state_next = S_PAUSE;
          end else if (!i_adclrck) begin
            state_next = S_RECV;
          end
        end
        S_RECV: begin
          if (bit_cnt_reg == CNT_LAST) state_next = S_WAITH;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg     <= S_IDLE;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      pause_req_reg <= 1'b0;
      o_data        <= '0;
      o_valid       <= 1'b0;
      o_address     <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      state_reg   <= state_next;
      o_busy      <= is_busy(state_next);
      o_done      <= (state_next == S_DONE);
      o_valid     <= 1'b0;
      bit_cnt_reg <= '0;

      if (!is_busy(state_next)) begin
        pause_req_reg <= 1'b0;
      end else if (i_pause && pause_armable) begin
        pause_req_reg <= 1'b1;
      end

      // A strobed sample still counts toward the address even if stop arrives with it.
      if (start_fresh) begin
        o_address <= '0;
      end else if (o_valid && (o_address != ADDR_LAST)) begin
        o_address <= o_address + 1'b1;
      end

      if ((state_reg == S_WAITL) && (state_next == S_RECV)) begin
        shift_reg   <= {{(DATA_W-2){1'b0}}, i_adcdat};
        bit_cnt_reg <= CNT_W'(1);
      end else if ((state_reg == S_RECV) && !i_stop) begin
        shift_reg <= shift_next[DATA_W-2:0];
        if (bit_cnt_reg == CNT_LAST) begin
          o_data  <= shift_next;
          o_valid <= 1'b1;
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/aud_recorder.md
Name: aud_recorder

Overview:
- Serial audio receiver for the codec ADC path. It deserialises left-channel 16-bit samples, MSB first, from the ADC serial data line, clocked by the codec bit clock.
- Each completed sample is presented as a parallel word with a one-cycle valid strobe and a sequential SRAM write address.
- Adds start/pause/stop recording control, frame-aligned synchronisation and end-of-memory detection.

Parameters:
- DATA_W, 16, sample width in bits and serial bits per frame.
- ADDR_W, 20, width of the write address.
- ADDR_LAST, 20'hFFFFF, last writable address; recording ends after this sample.

Ports:
- i_bclk  input  1  codec bit clock; all state updates on posedge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_adclrck  input  1  ADC LR clock; low = left channel.
- i_adcdat  input  1  ADC serial data, MSB first.
- i_start  input  1  level; begin a new recording, or resume from pause.
- i_pause  input  1  level; pause at the next sample boundary.
- i_stop  input  1  level; abort immediately.
- o_data  output  DATA_W  last completed sample, signed two's complement.
- o_valid  output  1  one-cycle strobe; o_data/o_address valid.
- o_address  output  ADDR_W  write address of the current/next sample.
- o_busy  output  1  high in any recording state (S_SYNC, S_WAITL, S_RECV, S_WAITH).
- o_done  output  1  high while in S_DONE.

Behaviour:
- Clocking/reset: one clock, i_bclk; reset is asynchronous and active-low on i_rst_n.
- Reset values: state S_IDLE; o_data 0; o_valid 0; o_address 0; o_busy 0; o_done 0; bit counter 0; shift register 0.
- States: S_IDLE, S_SYNC, S_WAITL, S_RECV, S_WAITH, S_PAUSE, S_DONE.
- S_IDLE: i_start -> S_SYNC, o_address <= 0.
- S_SYNC: i_adclrck==1 -> S_WAITH. This guarantees no capture starts mid-frame.
- S_WAITH: wait for i_adclrck==1 -> S_WAITL.
  - If the pause request flag is set, go to S_PAUSE instead.
- S_WAITL: on the first posedge with i_adclrck==0, capture i_adcdat as bit 15, counter <= 1, -> S_RECV.
- S_RECV: each posedge, shift in i_adcdat as bit (15-counter), counter++.
  - The posedge with counter==15 captures bit 0, then -> S_WAITH.
  - i_adclrck is not sampled in S_RECV.
- Output timing: on the cycle after bit 0 is captured, o_data holds the full word and o_valid=1 for exactly one cycle. o_address equals that sample's index during the strobe.
- Address update: on the cycle after the strobe, o_address increments by 1 unless it equals ADDR_LAST.
- End of memory: a strobe with o_address==ADDR_LAST -> S_DONE (no address wrap; o_address holds ADDR_LAST). o_done=1 from the cycle after the strobe.
- o_data hold: o_data holds its value between strobes. It is never updated from a partial sample.
- Pause: i_pause in S_WAITL/S_WAITH/S_RECV sets a pause request flag.
  - In S_WAITL, go -> S_PAUSE immediately.
  - Otherwise go -> S_PAUSE at the next S_WAITH exit, after the current sample strobes.
  - In S_PAUSE, o_address is held and o_busy=0.
  - i_start in S_PAUSE -> S_SYNC, address kept, flag cleared.
- Stop: i_stop in any state -> S_IDLE next cycle.
  - Any partial sample is discarded with no strobe.
  - o_address is retained (equals the number of samples recorded); o_done is cleared.
- S_DONE: i_start -> S_SYNC with o_address <= 0; i_stop -> S_IDLE.
- Priority when inputs are simultaneous: i_stop > i_pause > i_start.
- i_start while busy: ignored.
- Reset asserted mid-sample: immediate return to reset values, no strobe.

Test Plan:
- Basic capture: reset, i_start pulse, drive frames with left word 16'hA5C3, MSB first, on i_adclrck low. Expect: first frame after an lrck-high period is captured; o_valid one cycle after bit 0; o_data=16'hA5C3; o_address 0, then 1, 2 on successive frames.
- Mid-frame start: assert i_start while i_adclrck is low and 5 bits in. Expect: that frame is skipped; first strobe carries the next full frame's word.
- Pause/resume: i_pause asserted during bit 7 of sample 3. Expect: sample 3 strobes with o_address=3, then S_PAUSE with o_busy=0 for 10 frames and no strobes. After i_start, the next strobe has o_address=4.
- Stop mid-sample: i_stop at bit 9 of sample 2. Expect: no strobe for sample 2; o_address=2; o_busy=0; o_data keeps sample 1's value.
- End of memory: ADDR_LAST=3, record 5 frames (values 1..5). Expect: strobes for values 1..4 at addresses 0..3, then o_done=1, o_address=3, and no strobe for value 5.
- Async reset mid-S_RECV: deassert i_rst_n at bit 4. Expect: all outputs 0 immediately; after release, the block idles until i_start.
